// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller between the CPU and a multi-cycle block memory.
// Define DCACHE_STATS_EN to add saturating HIT_COUNT / MISS_COUNT outputs.
module dcache_controller #(
  parameter int NUM_BLOCKS = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [7:0]            WRITEDATA,
  output logic [7:0]            READDATA,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-3:0] MEM_ADDRESS,
  output logic [31:0]           MEM_WRITEDATA,
  input  logic [31:0]           MEM_READDATA,
  input  logic                  MEM_BUSYWAIT,
  output logic [1:0]            dbg_state
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]           HIT_COUNT,
  output logic [15:0]           MISS_COUNT
`endif
);

  localparam int IW = $clog2(NUM_BLOCKS);
  localparam int TW = ADDR_WIDTH - 2 - IW;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t                state;
  logic [TW-1:0]         tag_array  [NUM_BLOCKS];
  logic [31:0]           data_array [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;
  logic [31:0]           fetch_q;
  logic [7:0]            readdata_q;

  logic [1:0]    offset;
  logic [IW-1:0] index;
  logic [TW-1:0] tag;
  logic          req;
  logic          rd_req;
  logic          wr_req;
  logic          hit;
  logic          idle_hit;
  logic          idle_miss;
  logic [7:0]    sel_byte;

  assign offset    = ADDRESS[1:0];
  assign index     = ADDRESS[IW+1:2];
  assign tag       = ADDRESS[ADDR_WIDTH-1:IW+2];
  // READ and WRITE together is resolved as a store.
  assign wr_req    = WRITE;
  assign rd_req    = READ & ~WRITE;
  assign req       = READ | WRITE;
  assign hit       = valid[index] && (tag_array[index] == tag);
  assign idle_hit  = (state == IDLE) && req && hit;
  assign idle_miss = (state == IDLE) && req && !hit;
  assign sel_byte  = data_array[index][{offset, 3'b000} +: 8];

  assign READDATA  = (idle_hit && rd_req) ? sel_byte : readdata_q;
  assign BUSYWAIT  = (state != IDLE) || idle_miss;
  assign dbg_state = state;

  // Memory handshake: MEM_READ/MEM_WRITE (never both) are held with a stable MEM_ADDRESS and
  // MEM_WRITEDATA until a posedge sees MEM_BUSYWAIT low; that edge completes the transfer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      MEM_READ      <= 1'b0;
      MEM_WRITE     <= 1'b0;
      MEM_ADDRESS   <= '0;
      MEM_WRITEDATA <= '0;
      fetch_q       <= '0;
      readdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (rd_req) readdata_q <= sel_byte;
              if (wr_req) dirty[index] <= 1'b1;
            end else if (valid[index] && dirty[index]) begin
              state         <= WRITEBACK;
              MEM_WRITE     <= 1'b1;
              MEM_ADDRESS   <= {tag_array[index], index};
              MEM_WRITEDATA <= data_array[index];
            end else begin
              state       <= FETCH;
              MEM_READ    <= 1'b1;
              MEM_ADDRESS <= {tag, index};
            end
          end
        end
        WRITEBACK: begin
          if (!MEM_BUSYWAIT) begin
            state       <= FETCH;
            MEM_WRITE   <= 1'b0;
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= {tag, index};
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) begin
            state    <= UPDATE;
            MEM_READ <= 1'b0;
            fetch_q  <= MEM_READDATA;
          end
        end
        UPDATE: begin
          state        <= IDLE;
          valid[index] <= 1'b1;
          dirty[index] <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag storage are not cleared by reset; the valid bits guard them.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (idle_hit && wr_req) data_array[index][{offset, 3'b000} +: 8] <= WRITEDATA;
      if (state == UPDATE) begin
        data_array[index] <= fetch_q;
        tag_array[index]  <= tag;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // A request that missed is served later as a hit; it must not also count as a hit.
  logic missed;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
      missed     <= 1'b0;
    end else if ((state == IDLE) && req) begin
      if (hit) begin
        if (!missed && (HIT_COUNT != 16'hFFFF)) HIT_COUNT <= HIT_COUNT + 16'd1;
        missed <= 1'b0;
      end else begin
        if (MISS_COUNT != 16'hFFFF) MISS_COUNT <= MISS_COUNT + 16'd1;
        missed <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios plus random traffic against a
// transaction-level cache model and a behavioural multi-cycle memory.
module tb_dcache_controller;

  logic        clk = 1'b0;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;
  logic [1:0]  dbg_state;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count;
  logic [15:0] miss_count;
`endif

  dcache_controller #(.NUM_BLOCKS(8), .ADDR_WIDTH(8)) dut (
    .CLK(clk),
    .RESET(RESET),
    .READ(READ),
    .WRITE(WRITE),
    .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA),
    .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .dbg_state(dbg_state)
`ifdef DCACHE_STATS_EN
    ,
    .HIT_COUNT(hit_count),
    .MISS_COUNT(miss_count)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    if (a == 5) return 32'hDDCCBBAA;
    return {8'(a * 7 + 1), 8'(a * 3 + 2), 8'(a ^ 90), 8'(a + 64)};
  endfunction

  // ---------------- behavioural memory ----------------
  logic [31:0] mem [64];
  int          mem_cnt;
  int          mem_lat = 5;

  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (mem_cnt != mem_lat - 1);
  assign MEM_READDATA = mem[MEM_ADDRESS];

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_word(i);
    mem_cnt = 0;
    forever begin
      @(posedge clk);
      if (MEM_READ | MEM_WRITE) begin
        if (mem_cnt == mem_lat - 1) begin
          mem_cnt <= 0;
          if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
        end else begin
          mem_cnt <= mem_cnt + 1;
        end
      end else begin
        mem_cnt <= 0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [64];
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_data  [8];
  int          m_hits;
  int          m_misses;

  logic [37:0] exp_wb_q[$];
  logic [5:0]  exp_q[$];
  logic [7:0]  exp_rdata;
  logic [7:0]  last_rdata;
  logic        cur_req;
  logic        cur_rd;
  logic        mon_en;
  logic [5:0]  seen_fetch_addr;
  logic [5:0]  seen_wb_addr;
  logic [31:0] seen_wb_data;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
    exp_wb_q.delete();
    exp_q.delete();
    last_rdata = 8'h00;
  endtask

  // Miss stall = detection cycle in IDLE + memory cycles (+ write-back cycles) + UPDATE cycle.
  task automatic model_apply(input logic rd, input logic wr, input logic [7:0] addr,
                             input logic [7:0] wd, output int stall);
    int         idx = int'(addr[4:2]);
    int         off = int'(addr[1:0]);
    logic [2:0] tg  = addr[7:5];
    stall = 0;
    if (!(m_valid[idx] && (m_tag[idx] == tg))) begin
      m_misses++;
      stall = mem_lat + 2;
      if (m_valid[idx] && m_dirty[idx]) begin
        exp_wb_q.push_back({m_tag[idx], 3'(idx), m_data[idx]});
        ref_mem[{m_tag[idx], 3'(idx)}] = m_data[idx];
        stall += mem_lat;
      end
      exp_q.push_back({tg, 3'(idx)});
      m_data[idx]  = ref_mem[{tg, 3'(idx)}];
      m_tag[idx]   = tg;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end else begin
      m_hits++;
    end
    if (wr) begin
      m_data[idx][off*8 +: 8] = wd;
      m_dirty[idx] = 1'b1;
    end else if (rd) begin
      exp_rdata = m_data[idx][off*8 +: 8];
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a posedge; returns just after the posedge that completes the request.
  task automatic do_req(input logic rd, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wd, output int st);
    int st_exp;
    model_apply(rd, wr, addr, wd, st_exp);
    READ = rd; WRITE = wr; ADDRESS = addr; WRITEDATA = wd;
    cur_rd = rd & ~wr;
    cur_req = 1'b1;
    st = 0;
    while (1) begin
      @(negedge clk);
      if (!BUSYWAIT) break;
      st++;
      if (st > 200) break;
    end
    check("stall_cycles", 64'(st), 64'(st_exp));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    READ = 1'b0; WRITE = 1'b0;
    cur_req = 1'b0;
    cur_rd = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("mem_rd_wr_exclusive", MEM_READ & MEM_WRITE, 1'b0);
        if (MEM_WRITE) begin
          seen_wb_addr = MEM_ADDRESS;
          seen_wb_data = MEM_WRITEDATA;
          check("writeback_expected", exp_wb_q.size() != 0, 1'b1);
          if (exp_wb_q.size() != 0) begin
            check("wb_addr", MEM_ADDRESS, exp_wb_q[0][37:32]);
            check("wb_data", MEM_WRITEDATA, exp_wb_q[0][31:0]);
            if (!MEM_BUSYWAIT) void'(exp_wb_q.pop_front());
          end
        end
        if (MEM_READ) begin
          seen_fetch_addr = MEM_ADDRESS;
          check("fetch_after_wb", 64'(exp_wb_q.size()), 64'd0);
          check("fetch_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            check("fetch_addr", MEM_ADDRESS, exp_q[0]);
            if (!MEM_BUSYWAIT) void'(exp_q.pop_front());
          end
        end
        if (!cur_req) begin
          check("idle_busywait", BUSYWAIT, 1'b0);
          check("idle_mem_req", MEM_READ | MEM_WRITE, 1'b0);
          check("idle_readdata_hold", READDATA, last_rdata);
        end else if (cur_rd && !BUSYWAIT) begin
          check("readdata", READDATA, exp_rdata);
          last_rdata = exp_rdata;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int st;
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    cur_req = 1'b0; cur_rd = 1'b0; mon_en = 1'b0; exp_rdata = '0;
    seen_fetch_addr = '0; seen_wb_addr = '0; seen_wb_data = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    model_reset();
    repeat (2) @(posedge clk);
    #1 RESET = 1'b0;
    @(negedge clk);
    check("rst_busywait", BUSYWAIT, 1'b0);
    check("rst_mem_read", MEM_READ, 1'b0);
    check("rst_mem_write", MEM_WRITE, 1'b0);
    check("rst_mem_address", MEM_ADDRESS, 6'h00);
    check("rst_mem_writedata", MEM_WRITEDATA, 32'h0);
    check("rst_readdata", READDATA, 8'h00);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Cold read miss with a 5-cycle memory.
    mem_lat = 5;
    do_req(1'b1, 1'b0, 8'h14, 8'h00, st);
    check("s1_stall", 64'(st), 64'd7);
    check("s1_fetch_addr", seen_fetch_addr, 6'h05);
    check("s1_readdata", READDATA, 8'hAA);

    // Same block, different byte: hit.
    do_req(1'b1, 1'b0, 8'h17, 8'h00, st);
    check("s2_stall", 64'(st), 64'd0);
    check("s2_readdata", READDATA, 8'hDD);

    // Write hit dirties line 5, then conflicting read forces write-back.
    do_req(1'b0, 1'b1, 8'h15, 8'h5A, st);
    check("s3_write_hit_stall", 64'(st), 64'd0);
    do_req(1'b1, 1'b0, 8'h35, 8'h00, st);
    check("s3_wb_addr", seen_wb_addr, 6'h05);
    check("s3_wb_data", seen_wb_data, 32'hDDCC5AAA);
    check("s3_fetch_addr", seen_fetch_addr, 6'h0D);
    check("s3_stall", 64'(st), 64'd12);

    // Write miss to an invalid line, then read it back.
    do_req(1'b0, 1'b1, 8'h20, 8'h77, st);
    check("s4_fetch_addr", seen_fetch_addr, 6'h08);
    check("s4_stall", 64'(st), 64'd7);
    do_req(1'b1, 1'b0, 8'h20, 8'h00, st);
    check("s4_readdata", READDATA, 8'h77);
`ifdef DCACHE_STATS_EN
    check("stats_hits_3", hit_count, 16'd3);
    check("stats_misses_3", miss_count, 16'd3);
`endif
    // Evicting line 0 proves it was left dirty.
    do_req(1'b1, 1'b0, 8'h00, 8'h00, st);
    check("s4_dirty_wb_addr", seen_wb_addr, 6'h08);
    check("s4_dirty_wb_byte", seen_wb_data[7:0], 8'h77);
    idle(2);

    // Reset in the middle of a fetch.
    begin
      int dummy;
      model_apply(1'b1, 1'b0, 8'h54, 8'h00, dummy);
      READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h54;
      cur_req = 1'b1; cur_rd = 1'b1;
      repeat (2) @(negedge clk);
      check("s5_fetch_active", MEM_READ, 1'b1);
      #1;
      mon_en = 1'b0;
      RESET = 1'b1; READ = 1'b0;
      cur_req = 1'b0; cur_rd = 1'b0;
      @(posedge clk); #1;
      RESET = 1'b0;
      model_reset();
      @(negedge clk);
      check("s5_mem_read_dropped", MEM_READ, 1'b0);
      check("s5_busywait_dropped", BUSYWAIT, 1'b0);
      mon_en = 1'b1;
      @(posedge clk); #1;
      do_req(1'b1, 1'b0, 8'h14, 8'h00, st);
      check("s5_remiss_stall", 64'(st), 64'd7);
      check("s5_refetch_addr", seen_fetch_addr, 6'h05);
      check("s5_readdata", READDATA, 8'hAA);
    end

    // Random traffic over a few tags per index.
    for (int n = 0; n < 250; n++) begin
      logic [7:0] a;
      logic       r;
      logic       w;
      int         sel;
      mem_lat = $urandom_range(2, 5);
      a = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      sel = $urandom_range(0, 9);
      if (sel == 0) begin r = 1'b1; w = 1'b1; end
      else if (sel < 5) begin r = 1'b1; w = 1'b0; end
      else begin r = 1'b0; w = 1'b1; end
      do_req(r, w, a, 8'($urandom), st);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    check("end_wb_queue_empty", 64'(exp_wb_q.size()), 64'd0);
    check("end_fetch_queue_empty", 64'(exp_q.size()), 64'd0);
`ifdef DCACHE_STATS_EN
    check("stats_hits_final", hit_count, 16'(m_hits));
    check("stats_misses_final", miss_count, 16'(m_misses));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back data cache controller between the CPU datapath (lwd/lwi/swd/swi, READ/WRITE from the control unit) and the multi-cycle data memory.
- Serves hits without stalling; on misses it stalls the CPU via BUSYWAIT and sequences write-back of a dirty victim and fetch of the new block.
- Holds the tag/valid/dirty arrays and the data array internally.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; power of two; index width = log2(NUM_BLOCKS).
- ADDR_WIDTH, 8, CPU byte-address width; tag width = ADDR_WIDTH - 2 - log2(NUM_BLOCKS).

Ports:
- CLK  input  1  clock; all state changes on posedge CLK.
- RESET  input  1  synchronous, active-high reset.
- READ  input  1  CPU load request.
- WRITE  input  1  CPU store request.
- ADDRESS  input  ADDR_WIDTH  byte address = {tag, index, offset[1:0]}.
- WRITEDATA  input  8  store data.
- READDATA  output  8  load data.
- BUSYWAIT  output  1  CPU stall.
- MEM_READ  output  1  block fetch request.
- MEM_WRITE  output  1  block write-back request.
- MEM_ADDRESS  output  ADDR_WIDTH-2  block address {tag, index}.
- MEM_WRITEDATA  output  32  victim block; byte k = bits [8k+7:8k].
- MEM_READDATA  input  32  fetched block.
- MEM_BUSYWAIT  input  1  high while memory is busy; low when transaction is complete.

Behaviour:
- Clocking and reset: one clock CLK; RESET is synchronous and active-high.
  - On a posedge with RESET=1: state goes to IDLE and all valid and dirty bits clear.
  - Outputs after reset: BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, READDATA=0.
  - RESET mid-miss abandons the transaction; request lines drop after that edge. Data/tag arrays need not be cleared.
- Hit detection (combinational): hit = valid[index] & (tag_array[index]==tag). Only READ|WRITE requests are evaluated.
- States: IDLE, WRITEBACK, FETCH, UPDATE.
- IDLE:
  - Read hit: READDATA = selected byte in the same cycle; BUSYWAIT=0.
  - Write hit: BUSYWAIT=0; at the next posedge, byte[offset] <= WRITEDATA and dirty[index] <= 1.
  - Miss: BUSYWAIT=1 combinationally. Next state is WRITEBACK if valid&dirty, else FETCH.
  - No request: BUSYWAIT=0; READDATA holds the last value.
- WRITEBACK:
  - Drives MEM_WRITE=1, MEM_ADDRESS={tag_array[index], index}, MEM_WRITEDATA=data_array[index].
  - Advances to FETCH at the first posedge with MEM_BUSYWAIT=0.
- FETCH:
  - Drives MEM_READ=1, MEM_ADDRESS={tag, index}.
  - At the first posedge with MEM_BUSYWAIT=0, captures MEM_READDATA and goes to UPDATE.
- UPDATE (1 cycle):
  - Writes the block, tag, valid=1, dirty=0; returns to IDLE.
  - The pending request then hits, so a store completes as a normal write hit.
- Memory handshake:
  - Memory raises MEM_BUSYWAIT combinationally in the same cycle MEM_READ/MEM_WRITE rises.
  - MEM_READ and MEM_WRITE are never high together. Requests are held stable until completion.
- BUSYWAIT = 1 in every non-IDLE state, and in IDLE on a miss.
- CPU obligation: READ/WRITE/ADDRESS/WRITEDATA must stay stable while BUSYWAIT=1.
- READ and WRITE both high is illegal: treated as WRITE.
- Miss latency: memory cycles + 1 UPDATE cycle, plus write-back time if the victim is dirty.
- Index wrap: the highest index is a normal line; there is no special case.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0]. Both reset to 0 and saturate at 16'hFFFF.
  - HIT_COUNT increments once per request completed in IDLE without a preceding miss.
  - MISS_COUNT increments once on each IDLE->WRITEBACK/FETCH transition.
- Undefined: the counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then READ ADDRESS=8'h14 with a 5-cycle memory:
  - Expect BUSYWAIT=1, MEM_READ=1, MEM_ADDRESS=6'h05, no MEM_WRITE.
  - With MEM_READDATA=32'hDDCCBBAA, expect READDATA=8'hAA and BUSYWAIT=0 after UPDATE.
- READ 8'h17 immediately afterwards:
  - Expect a hit with READDATA=8'hDD in the same cycle and no memory request.
- WRITE 8'h15 data 8'h5A (hit), then READ 8'h35 (same index, new tag):
  - Expect WRITEBACK first with MEM_ADDRESS=6'h05 and MEM_WRITEDATA=32'hDDCC5AAA.
  - Then FETCH with MEM_ADDRESS=6'h0D.
- WRITE miss to a clean/invalid line 8'h20 data 8'h77:
  - Expect FETCH only, then byte written; a following READ 8'h20 returns 8'h77 with dirty set.
- Assert RESET during FETCH:
  - Expect MEM_READ=0 and BUSYWAIT=0 after the edge, and READ 8'h14 misses again.
- With DCACHE_STATS_EN, run the sequence above:
  - Expect HIT_COUNT and MISS_COUNT to match a scoreboard, e.g. 3 misses and 3 hits for the first four scenarios.
